// File: rtl/deser_pkg.sv
// deser_pkg: shared FSM state type and default word width for the deserializer
package deser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} deser_state_t;
  localparam int DESER_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: counts received bits, flags the last bit of a word
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over load (first bit), load wins over increment
  always_comb cnt_d = clr_i ? '0 : load_i ? CW'(1) : inc_i ? cnt_q + CW'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // high while the next sampled bit is the last one of the word
  assign tc_o = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/deserializer.sv
// deserializer: collects WIDTH serial bits into one parallel word with a valid pulse
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdata,
  input  logic             start,
  output logic [WIDTH-1:0] pdata,
  output logic             valid
);
  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, pdata_q, pdata_d, shift_src, shift_w;
  logic             valid_q, valid_d, cnt_clr, cnt_load, cnt_inc, cnt_tc;
  deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );
  // a new word starts from zero so the IDLE->SHIFT edge captures bit 0 cleanly
  assign shift_src = (state_q == SHIFT) ? shreg_q : '0;
  assign shift_w   = (MSB_FIRST != 0) ? ((shift_src << 1) | WIDTH'(sdata))
                                      : ((shift_src >> 1) | {sdata, {(WIDTH-1){1'b0}}});
  // next-state, shift, completion and counter control
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pdata_d  = pdata_q;
    valid_d  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shreg_d  = shift_w;
        cnt_load = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: if (!start) begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end else begin
        shreg_d = shift_w;
        cnt_inc = 1'b1;
        if (cnt_tc) begin
          pdata_d = shift_w;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (!start) begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, shift register and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
    end
  end
  assign pdata = pdata_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of MSB-first and LSB-first deserializers on shared stimulus
module tb_deserializer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sdata = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pdata_m, pdata_l;
  logic        valid_m, valid_l;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(16), .MSB_FIRST(1)) dut (
    .clk(clk), .reset_n(reset_n), .sdata(sdata), .start(start), .pdata(pdata_m), .valid(valid_m)
  );
  deserializer #(.WIDTH(16), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .sdata(sdata), .start(start), .pdata(pdata_l), .valid(valid_l)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vm, input logic [15:0] pm,
                         input logic vl, input logic [15:0] pl);
    chk({tag, "_valid_msb"}, 16'(valid_m), 16'(vm));
    chk({tag, "_pdata_msb"}, pdata_m, pm);
    chk({tag, "_valid_lsb"}, 16'(valid_l), 16'(vl));
    chk({tag, "_pdata_lsb"}, pdata_l, pl);
  endtask

  task automatic send_bits(input string tag, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_nopulse_msb"}, 16'(valid_m), 16'h0);
      chk({tag, "_nopulse_lsb"}, 16'(valid_l), 16'h0);
      start = 1'b1;
      sdata = w[15-i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_edge(input string tag, input logic [15:0] pm, input logic [15:0] pl);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_out(tag, 1'b0, pm, 1'b0, pl);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      sdata = 1'b1;
      chk_out("reset_hold", 1'b0, 16'h0000, 1'b0, 16'h0000);
    end
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("reset_release", 1'b0, 16'h0000, 1'b0, 16'h0000);

    send_bits("w1", 16'hA5A5, 16);
    chk_out("w1_done", 1'b1, 16'hA5A5, 1'b1, 16'hA5A5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sdata = 1'($urandom);
      @(posedge clk);
      #1;
      chk_out("hold_after_done", 1'b0, 16'hA5A5, 1'b0, 16'hA5A5);
    end
    idle_edge("w1_rearm", 16'hA5A5, 16'hA5A5);

    send_bits("w2", 16'h3C3C, 16);
    chk_out("w2_done", 1'b1, 16'h3C3C, 1'b1, 16'h3C3C);
    idle_edge("w2_rearm", 16'h3C3C, 16'h3C3C);

    send_bits("abort", 16'hFE00, 7);
    chk_out("abort_partial", 1'b0, 16'h3C3C, 1'b0, 16'h3C3C);
    idle_edge("abort_drop", 16'h3C3C, 16'h3C3C);
    send_bits("w3", 16'hFFFF, 16);
    chk_out("w3_done", 1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    idle_edge("w3_rearm", 16'hFFFF, 16'hFFFF);

    send_bits("w4", 16'h0001, 16);
    chk_out("w4_done", 1'b1, 16'h0001, 1'b1, 16'h8000);
    idle_edge("w4_rearm", 16'h0001, 16'h8000);

    send_bits("midword", 16'hFFFF, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
    send_bits("w5", 16'h1234, 16);
    chk_out("w5_done", 1'b1, 16'h1234, 1'b1, 16'h2C48);
    idle_edge("w5_rearm", 16'h1234, 16'h2C48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
